bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
Parametrised bus arbiter for the shared system bus. It generalises the fixed 6-requester arbiter to N masters and adds:
- selectable fixed-priority or round-robin arbitration;
- a one-cycle bus turnaround between owners;
- a tenure timeout that forcibly revokes a stuck grant.

It sits beside bus_controller and drives the one-hot grant vector that masters sample before driving D/A/MASTER/DEST/SIZE/RW.

Parameters:
N_MASTERS, 6, number of requesters (2..16)
ID_W, 3, width of GNT_ID; must satisfy 2**ID_W >= N_MASTERS
TIMEOUT, 64, maximum cycles one master may hold the grant (1..2**TO_W-1)
TO_W, 7, width of the tenure counter

Ports:
BUS_CLK  input  1  bus clock; all state changes on rising edge
RST  input  1  asynchronous, active-low reset
BR  input  N_MASTERS  bus request, one bit per master, level-sensitive
MODE  input  1  0 = fixed priority (lowest index wins), 1 = round-robin
BG  output  N_MASTERS  bus grant, one-hot or all-zero, registered
GNT_VALID  output  1  high while any BG bit is high
GNT_ID  output  ID_W  index of current owner; 0 when GNT_VALID low
TIMEOUT_ERR  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (RST low, asynchronous): state=IDLE; BG=0, GNT_VALID=0, GNT_ID=0, TIMEOUT_ERR=0; rr pointer=0; tenure=0; mask=0. On release of RST, arbitration starts on the first rising edge.
- All outputs are registered. No combinational path from BR to BG.
- States: IDLE, GRANT, TURN.
- IDLE:
  - Eligible set E = BR & ~mask.
  - If E != 0: pick winner W and enter GRANT. BG[W] is set on the same edge, so latency from BR rise to BG is 1 cycle.
  - Else stay in IDLE.
- Winner selection:
  - MODE=0: lowest set index of E.
  - MODE=1: first set index of E searching from rr pointer upward, with wrap-around from N_MASTERS-1 to 0.
  - On every grant, rr pointer := (W+1) mod N_MASTERS, in both modes.
  - MODE is sampled only at the arbitration edge. Changing MODE mid-tenure has no effect on the current owner.
- GRANT:
  - tenure counts cycles from 1 upward.
  - If BR[W] is low: clear BG and enter TURN; tenure := 0.
  - Else if tenure == TIMEOUT: clear BG, set mask[W]=1, pulse TIMEOUT_ERR for one cycle, enter TURN.
  - Else: hold BG.
  - Requests from other masters never pre-empt the owner.
- TURN:
  - Exactly one cycle with BG=0 (bus turnaround), then IDLE.
  - Arbitration occurs on the IDLE edge. Minimum gap between successive grants is 2 cycles with BG all-zero.
- Mask:
  - mask[i] clears when BR[i] is observed low. A timed-out master must drop its request before it can be regranted.
  - Masked requesters are invisible to both arbitration modes.
- Simultaneous events:
  - Release and timeout on the same cycle: release wins, with no TIMEOUT_ERR and no mask.
  - A request arriving during TURN is considered at the following IDLE edge.
- Grant width: BG never has more than one bit set. GNT_ID always equals the index of the set bit.
- Reset mid-grant: BG drops asynchronously. No TIMEOUT_ERR is generated.

Optional Feature:
BUS_ARB_LOCK_EN
- Defined:
  - Adds input LOCK (1 bit). While BG is high and LOCK=1, the tenure counter holds and the timeout cannot fire; used for atomic read-modify-write sequences.
  - LOCK is ignored when no grant is active.
  - Release still ends tenure normally.
- Undefined: no LOCK port; timeout applies unconditionally.

Test Plan:
- N=6, MODE=0, BR=6'b101100 held -> BG=6'b000100 one cycle later. Drop BR[2] -> BG=0 for 2 cycles, then BG=6'b001000.
- MODE=1, BR=6'b111111 held, each owner releases after 3 cycles and re-requests -> grant order 0,1,2,3,4,5,0. Exactly 2 idle cycles between each grant.
- TIMEOUT=8, BR[1] held high forever with BR[4]=1 -> BG[1] high 8 cycles. TIMEOUT_ERR pulses once, then BG[4]. BG[1] is not regranted until BR[1] drops and rises again.
- BR[3] drops on the same edge tenure reaches TIMEOUT -> TIMEOUT_ERR stays 0, mask[3]=0, and BG[3] is regranted when BR[3] re-asserts with no competitors.
- RST pulled low while BG=6'b010000 -> BG=0, GNT_VALID=0, GNT_ID=0 immediately (asynchronous, before the next edge). After release, MODE=1 with BR=6'b010001 -> BG=6'b000001 (rr pointer reset to 0).
- With BUS_ARB_LOCK_EN, TIMEOUT=8, BR[2] and LOCK held for 20 cycles -> BG[2] high all 20 cycles, no TIMEOUT_ERR. LOCK drops -> timeout fires after tenure reaches 8.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr
// Parametrised N-master bus arbiter for the shared system bus. It supports
// fixed-priority or round-robin arbitration, a one-cycle turnaround between
// owners, and a tenure timeout that revokes a stuck grant. A master whose
// grant is revoked is masked until it drops its request.
//
// Optional feature: define BUS_ARB_LOCK_EN to add the LOCK input. While a
// grant is active and LOCK=1 the tenure counter freezes, so the timeout
// cannot fire during atomic read-modify-write sequences.
//
// Ports:
//   BUS_CLK      in   bus clock, rising edge
//   RST          in   asynchronous active-low reset
//   BR           in   [N_MASTERS] level-sensitive bus requests
//   MODE         in   0 = fixed priority (lowest index), 1 = round-robin
//   LOCK         in   (BUS_ARB_LOCK_EN only) freeze tenure while granted
//   BG           out  [N_MASTERS] registered one-hot grant (or all zero)
//   GNT_VALID    out  high while any BG bit is high
//   GNT_ID       out  [ID_W] index of current owner, 0 when idle
//   TIMEOUT_ERR  out  one-cycle pulse when a grant is revoked by timeout

module bus_arbiter_rr #(
    parameter int N_MASTERS = 6,
    parameter int ID_W      = 3,
    parameter int TIMEOUT   = 64,
    parameter int TO_W      = 7
) (
    input  logic                 BUS_CLK,
    input  logic                 RST,
    input  logic [N_MASTERS-1:0] BR,
    input  logic                 MODE,
`ifdef BUS_ARB_LOCK_EN
    input  logic                 LOCK,
`endif
    output logic [N_MASTERS-1:0] BG,
    output logic                 GNT_VALID,
    output logic [ID_W-1:0]      GNT_ID,
    output logic                 TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    localparam logic [TO_W-1:0]      TO_LIM  = TO_W'(TIMEOUT);
    localparam logic [N_MASTERS-1:0] ONE_HOT = N_MASTERS'(1);
    localparam logic [ID_W-1:0]      LAST_ID = ID_W'(N_MASTERS - 1);

    state_t                 state;
    logic [ID_W-1:0]        rr_ptr;
    logic [TO_W-1:0]        tenure;
    logic [N_MASTERS-1:0]   mask;

    logic [N_MASTERS-1:0]   eligible;
    logic                   win_found;
    logic [ID_W-1:0]        win_id;
    logic [ID_W-1:0]        win_next_ptr;
    logic                   owner_req;
    logic                   hold_tenure;

    // Bit select by a run-time index without requiring the index width to
    // match the vector's address width.
    function automatic logic bit_at(input logic [N_MASTERS-1:0] v, input int idx);
        logic [N_MASTERS-1:0] s;
        s = v >> idx;
        return s[0];
    endfunction

`ifdef BUS_ARB_LOCK_EN
    assign hold_tenure = LOCK;
`else
    assign hold_tenure = 1'b0;
`endif

    assign owner_req = bit_at(BR, int'(GNT_ID));

    // Winner search. Fixed priority scans from index 0; round-robin scans
    // from rr_ptr with wrap-around. Masked requesters never participate.
    always_comb begin
        // NOTE: every variable gets a default first so no path through this
        // block leaves a value unassigned, which would infer a latch.
        eligible  = BR & ~mask;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            int idx;
            idx = MODE ? (int'(rr_ptr) + i) % N_MASTERS : i;
            if (!win_found && bit_at(eligible, idx)) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
        win_next_ptr = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
    end

    always_ff @(posedge BUS_CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            BG          <= '0;
            GNT_VALID   <= 1'b0;
            GNT_ID      <= '0;
            TIMEOUT_ERR <= 1'b0;
            rr_ptr      <= '0;
            tenure      <= '0;
            mask        <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees register values from before this edge.
            TIMEOUT_ERR <= 1'b0;
            // A masked master is released as soon as its request is seen low.
            mask        <= mask & BR;

            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= GRANT;
                        BG        <= ONE_HOT << win_id;
                        GNT_VALID <= 1'b1;
                        GNT_ID    <= win_id;
                        rr_ptr    <= win_next_ptr;
                        tenure    <= TO_W'(1);
                    end
                end

                GRANT: begin
                    // Release is checked first so that a release coinciding
                    // with the timeout cycle is a clean release.
                    if (!owner_req) begin
                        state     <= TURN;
                        BG        <= '0;
                        GNT_VALID <= 1'b0;
                        GNT_ID    <= '0;
                        tenure    <= '0;
                    end else if (hold_tenure) begin
                        tenure <= tenure;
                    end else if (tenure == TO_LIM) begin
                        state       <= TURN;
                        BG          <= '0;
                        GNT_VALID   <= 1'b0;
                        GNT_ID      <= '0;
                        tenure      <= '0;
                        mask        <= (mask & BR) | (ONE_HOT << GNT_ID);
                        TIMEOUT_ERR <= 1'b1;
                    end else begin
                        tenure <= tenure + TO_W'(1);
                    end
                end

                TURN: begin
                    // One dead cycle so the old owner's drivers release.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Testbench for bus_arbiter_rr (N_MASTERS=6, TIMEOUT=8). Directed scenarios
// followed by a randomized phase; every cycle is compared against a
// transaction-level model of owner / hold count / gap / masked set.

module tb_bus_arbiter_rr;

    localparam int N  = 6;
    localparam int TO = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] br;
    logic         mode;
    logic         lock;
    logic [N-1:0] bg;
    logic         gnt_valid;
    logic [2:0]   gnt_id;
    logic         timeout_err;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int           m_owner;   // -1 when nobody owns the bus
    int           m_held;    // cycles the owner has held BG so far
    int           m_gap;     // non-arbitrating edges still to pass
    int           m_start;   // round-robin search origin
    logic [N-1:0] m_mask;
    logic         m_err;

    bus_arbiter_rr #(
        .N_MASTERS(N),
        .ID_W(3),
        .TIMEOUT(TO),
        .TO_W(7)
    ) dut (
        .BUS_CLK(clk),
        .RST(rst_n),
        .BR(br),
        .MODE(mode),
`ifdef BUS_ARB_LOCK_EN
        .LOCK(lock),
`endif
        .BG(bg),
        .GNT_VALID(gnt_valid),
        .GNT_ID(gnt_id),
        .TIMEOUT_ERR(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_of(input logic [N-1:0] v, input int idx);
        logic [N-1:0] s;
        s = v >> idx;
        return s[0];
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_start = 0;
        m_mask  = '0;
        m_err   = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        logic         locked;
        logic [N-1:0] old_mask;
        int           w;
        locked   = 1'b0;
`ifdef BUS_ARB_LOCK_EN
        locked   = lock;
`endif
        old_mask = m_mask;
        m_err    = 1'b0;
        if (m_owner >= 0) begin
            if (!bit_of(br, m_owner)) begin
                m_owner = -1;
                m_gap   = 1;
            end else if (locked) begin
                m_held = m_held;
            end else if (m_held == TO) begin
                m_mask  = m_mask | (N'(1) << m_owner);
                m_err   = 1'b1;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = mode ? (m_start + k) % N : k;
                if (w < 0 && bit_of(br, c) && !bit_of(old_mask, c)) w = c;
            end
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_start = (w + 1) % N;
            end
        end
        m_mask = m_mask & br;
    endtask

    task automatic compare_model();
        int exp_bg;
        exp_bg = (m_owner >= 0) ? (1 << m_owner) : 0;
        check("model_bg", 32'(bg), 32'(exp_bg));
        check("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("model_gnt_id", 32'(gnt_id), 32'((m_owner >= 0) ? m_owner : 0));
        check("model_timeout_err", 32'(timeout_err), 32'(m_err));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            compare_model();
        end
    endtask

    // Assert reset away from the clock edge, confirm outputs clear before
    // any edge, then release away from the edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_bg"}, 32'(bg), 32'h0);
        check({tag, "_gnt_valid"}, 32'(gnt_valid), 32'h0);
        check({tag, "_gnt_id"}, 32'(gnt_id), 32'h0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        br    = '0;
        mode  = 1'b0;
        lock  = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset("reset");

        // Fixed priority: lowest of 2,3,5 wins; after release two idle cycles.
        mode = 1'b0;
        br   = 6'b101100;
        tick(1);
        check("fp_first_grant", 32'(bg), 32'h04);
        tick(2);
        br = 6'b101000;
        tick(1);
        check("fp_turn_gap1", 32'(bg), 32'h00);
        tick(1);
        check("fp_turn_gap2", 32'(bg), 32'h00);
        tick(1);
        check("fp_second_grant", 32'(bg), 32'h08);
        br = '0;
        tick(3);

        // Round-robin with everyone requesting: order 0..5,0.
        do_reset("rr_reset");
        mode = 1'b1;
        br   = '1;
        tick(1);
        for (int k = 0; k <= N; k++) begin
            check("rr_order", 32'(bg), 32'(1 << (k % N)));
            tick(2);
            br = br & ~(N'(1) << (k % N));
            tick(1);
            check("rr_idle1", 32'(bg), 32'h00);
            br = br | (N'(1) << (k % N));
            tick(1);
            check("rr_idle2", 32'(bg), 32'h00);
            tick(1);
        end
        br = '0;
        tick(4);

        // Timeout: master 1 holds forever, master 4 waiting.
        mode = 1'b0;
        br   = 6'b010010;
        tick(1);
        check("to_grant1", 32'(bg), 32'h02);
        tick(TO - 1);
        check("to_still_held", 32'(bg), 32'h02);
        check("to_no_err_yet", 32'(timeout_err), 32'h0);
        tick(1);
        check("to_revoked", 32'(bg), 32'h00);
        check("to_err_pulse", 32'(timeout_err), 32'h1);
        tick(1);
        check("to_err_one_cycle", 32'(timeout_err), 32'h0);
        tick(1);
        check("to_grant4", 32'(bg), 32'h10);
        br = 6'b000010;
        tick(3);
        check("to_masked", 32'(bg), 32'h00);
        tick(2);
        check("to_still_masked", 32'(bg), 32'h00);
        br = '0;
        tick(1);
        br = 6'b000010;
        tick(1);
        check("to_regrant_after_drop", 32'(bg), 32'h02);
        br = '0;
        tick(3);

        // Release on the same edge the timeout would fire.
        br = 6'b001000;
        tick(1);
        tick(TO - 1);
        br = '0;
        tick(1);
        check("race_no_err", 32'(timeout_err), 32'h0);
        br = 6'b001000;
        tick(1);
        tick(1);
        check("race_regrant", 32'(bg), 32'h08);
        br = '0;
        tick(3);

        // Asynchronous reset mid-grant, then round-robin pointer restarts at 0.
        mode = 1'b0;
        br   = 6'b010000;
        tick(1);
        check("rst_pre_grant", 32'(bg), 32'h10);
        tick(1);
        do_reset("rst_mid_grant");
        mode = 1'b1;
        br   = 6'b010001;
        tick(1);
        check("rst_rr_grant0", 32'(bg), 32'h01);
        br = '0;
        tick(3);
        mode = 1'b0;
        br   = 6'b000100;
        tick(1);
        check("rst_pre_grant2", 32'(bg), 32'h04);
        do_reset("rst_mid_grant2");
        mode = 1'b1;
        br   = 6'b010010;
        tick(1);
        check("rst_rr_ptr_cleared", 32'(bg), 32'h02);
        br = '0;
        tick(3);

`ifdef BUS_ARB_LOCK_EN
        // Locked tenure outlives the timeout; timeout resumes once unlocked.
        mode = 1'b0;
        br   = 6'b000100;
        lock = 1'b1;
        tick(20);
        check("lock_held_20", 32'(bg), 32'h04);
        check("lock_no_err", 32'(timeout_err), 32'h0);
        lock = 1'b0;
        tick(TO - 1);
        check("lock_release_held", 32'(bg), 32'h04);
        tick(1);
        check("lock_timeout_fires", 32'(timeout_err), 32'h1);
        br = '0;
        tick(3);
`endif

        // Randomized phase: sticky requests flip ~1/8 per bit per cycle.
        for (int c = 0; c < 800; c++) begin
            br = br ^ (N'($urandom) & N'($urandom) & N'($urandom));
            if ($urandom_range(31) == 0) mode = ~mode;
            if ($urandom_range(15) == 0) lock = ~lock;
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
